lfsr_pair_checker: RTL and testbench

Receive-side checker for LFSR stimulus. It consumes a stream of (current value, next value) pairs on `seq_num`/`sw_in`, the same pairing the team's stimulus modules drive. For each pair it recomputes the LFSR next state and checks it, and it checks continuity between consecutive pairs. Counters and sticky flags report the result. It sits between the stimulus source (or the DUT LFSR output tap) and the scoreboard, in simulation and on the board.

---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_pair_checker_if.sv | 32 +++
 rtl/lfsr_step_comb.sv | 14 +
 rtl/lfsr_pair_checker.sv | 132 +++++++++++++
 tb/tb_lfsr_pair_checker.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR helpers, default taps and checker state encoding
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_W = 32;
    localparam logic [LFSR_MAX_W-1:0] LFSR_DEF_TAPS = 32'h0000_00B8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Fibonacci step on a word right-aligned in LFSR_MAX_W bits; bits above width are cleared.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] cur,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           width
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        mask = '1;
        if (width < LFSR_MAX_W) begin
            mask = (LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1);
        end
        fb = ^(cur & taps & mask);
        return ((cur << 1) | LFSR_MAX_W'(fb)) & mask;
    endfunction

endpackage

// File: rtl/lfsr_pair_checker_if.sv
// rtl/lfsr_pair_checker_if.sv - pair stream and result bundle for lfsr_pair_checker
interface lfsr_pair_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [WIDTH-1:0] seq_num;
    logic [WIDTH-1:0] sw_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] pair_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err_idx;
    logic             res_valid;
    logic             res_fail;

    modport slave (
        input  start, in_valid, in_last, seq_num, sw_in,
        output in_ready, busy, done, err, pair_cnt, err_cnt, first_err_idx,
               res_valid, res_fail
    );

    modport master (
        output start, in_valid, in_last, seq_num, sw_in,
        input  in_ready, busy, done, err, pair_cnt, err_cnt, first_err_idx,
               res_valid, res_fail
    );
endinterface

// File: rtl/lfsr_step_comb.sv
// rtl/lfsr_step_comb.sv - combinational single-step LFSR next-state
module lfsr_step_comb
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] taps_i,
    output logic [WIDTH-1:0] nxt_o
);

    assign nxt_o = WIDTH'(lfsr_next(LFSR_MAX_W'(cur_i), LFSR_MAX_W'(taps_i), WIDTH));

endmodule

// File: rtl/lfsr_pair_checker.sv
// rtl/lfsr_pair_checker.sv - checks (current, next) LFSR pairs for step, continuity and lock-up
module lfsr_pair_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEF_TAPS),
    parameter int               CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    lfsr_pair_checker_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_sw_q, prev_sw_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] first_err_q, first_err_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             res_valid_q, res_valid_d;
    logic             res_fail_q, res_fail_d;

    logic [WIDTH-1:0] exp_w;
    logic             accept;
    logic             fail;

    lfsr_step_comb #(.WIDTH(WIDTH)) u_step (
        .cur_i  (bus.seq_num),
        .taps_i (TAPS),
        .nxt_o  (exp_w)
    );

    assign accept = bus.in_valid && (state_q == ST_RUN);
    assign fail   = (bus.sw_in != exp_w)
                 || (!first_q && (bus.seq_num != prev_sw_q))
                 || (bus.seq_num == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prev_sw_q   <= '0;
            first_q     <= 1'b1;
            pair_cnt_q  <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '1;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_sw_q   <= prev_sw_d;
            first_q     <= first_d;
            pair_cnt_q  <= pair_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_q       <= err_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_fail_q  <= res_fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_sw_d   = prev_sw_q;
        first_d     = first_q;
        pair_cnt_d  = pair_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_d       = err_q;
        done_d      = (state_q == ST_FLUSH);
        res_valid_d = 1'b0;
        res_fail_d  = res_fail_q;

        case (state_q)
            ST_IDLE: begin
                // done_q marks the single IDLE cycle right after a run, where start is not honoured
                if (bus.start && !done_q) begin
                    state_d     = ST_RUN;
                    pair_cnt_d  = '0;
                    err_cnt_d   = '0;
                    err_d       = 1'b0;
                    first_d     = 1'b1;
                    first_err_d = '1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    res_valid_d = 1'b1;
                    res_fail_d  = fail;
                    prev_sw_d   = bus.sw_in;
                    first_d     = 1'b0;
                    if (pair_cnt_q != '1) begin
                        pair_cnt_d = pair_cnt_q + CNT_W'(1);
                    end
                    if (fail) begin
                        err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (first_err_q == '1) begin
                            first_err_d = pair_cnt_q;
                        end
                    end
                    if (bus.in_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready      = (state_q == ST_RUN);
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.pair_cnt      = pair_cnt_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.first_err_idx = first_err_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_fail      = res_fail_q;

endmodule

// File: tb/tb_lfsr_pair_checker.sv
// tb/tb_lfsr_pair_checker.sv - directed table-driven bench for lfsr_pair_checker
module tb_lfsr_pair_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_pair_checker_if #(.WIDTH(8), .CNT_W(8)) bus ();
    lfsr_pair_checker_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

    assign bus2.start    = bus.start;
    assign bus2.in_valid = bus.in_valid;
    assign bus2.in_last  = bus.in_last;
    assign bus2.seq_num  = bus.seq_num;
    assign bus2.sw_in    = bus.sw_in;

    lfsr_pair_checker #(.WIDTH(8), .TAPS(8'hB8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lfsr_pair_checker #(.WIDTH(8), .TAPS(8'hB8), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [7:0] seq;
        logic [7:0] sw;
        logic       last;
        logic       fail;
    } vec_t;

    typedef struct {
        int         lo;
        int         hi;
        logic [7:0] pc;
        logic [7:0] ec;
        logic       err;
        logic [7:0] fi;
    } run_t;

    vec_t vecs[9];
    run_t runs[4];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("in_ready after start", 32'(bus.in_ready), 32'd1);
        chk("busy after start", 32'(bus.busy), 32'd1);
    endtask

    task automatic run_chain(input int r);
        do_start();
        for (int i = runs[r].lo; i <= runs[r].hi; i++) begin
            bus.in_valid = 1'b1;
            bus.seq_num  = vecs[i].seq;
            bus.sw_in    = vecs[i].sw;
            bus.in_last  = vecs[i].last;
            step();
            chk($sformatf("res_valid run%0d vec%0d", r, i), 32'(bus.res_valid), 32'd1);
            chk($sformatf("res_fail run%0d vec%0d", r, i), 32'(bus.res_fail), 32'(vecs[i].fail));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk($sformatf("busy in flush run%0d", r), 32'(bus.busy), 32'd1);
        chk($sformatf("done early run%0d", r), 32'(bus.done), 32'd0);
        step();
        chk($sformatf("done pulse run%0d", r), 32'(bus.done), 32'd1);
        chk($sformatf("busy after done run%0d", r), 32'(bus.busy), 32'd0);
        step();
        chk($sformatf("done single run%0d", r), 32'(bus.done), 32'd0);
        chk($sformatf("pair_cnt run%0d", r), 32'(bus.pair_cnt), 32'(runs[r].pc));
        chk($sformatf("err_cnt run%0d", r), 32'(bus.err_cnt), 32'(runs[r].ec));
        chk($sformatf("err run%0d", r), 32'(bus.err), 32'(runs[r].err));
        chk($sformatf("first_err_idx run%0d", r), 32'(bus.first_err_idx), 32'(runs[r].fi));
    endtask

    initial begin
        // good chain, step error, continuity error, lock-up
        vecs[0] = '{8'h01, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h02, 8'h04, 1'b0, 1'b0};
        vecs[2] = '{8'h04, 8'h08, 1'b0, 1'b0};
        vecs[3] = '{8'h08, 8'h11, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 8'h02, 1'b0, 1'b0};
        vecs[5] = '{8'h02, 8'h05, 1'b1, 1'b1};
        vecs[6] = '{8'h01, 8'h02, 1'b0, 1'b0};
        vecs[7] = '{8'h04, 8'h08, 1'b1, 1'b1};
        vecs[8] = '{8'h00, 8'h00, 1'b1, 1'b1};
        runs[0] = '{0, 3, 8'd4, 8'd0, 1'b0, 8'hFF};
        runs[1] = '{4, 5, 8'd2, 8'd1, 1'b1, 8'h01};
        runs[2] = '{6, 7, 8'd2, 8'd1, 1'b1, 8'h01};
        runs[3] = '{8, 8, 8'd1, 8'd1, 1'b1, 8'h00};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.seq_num  = '0;
        bus.sw_in    = '0;
        step();
        rst = 1'b0;
        chk("reset in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset res_valid", 32'(bus.res_valid), 32'd0);
        chk("reset res_fail", 32'(bus.res_fail), 32'd0);
        chk("reset err", 32'(bus.err), 32'd0);
        chk("reset pair_cnt", 32'(bus.pair_cnt), 32'd0);
        chk("reset err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("reset first_err_idx", 32'(bus.first_err_idx), 32'hFF);

        for (int r = 0; r < 4; r++) begin
            run_chain(r);
        end

        // in_valid while IDLE must not be counted
        bus.in_valid = 1'b1;
        bus.seq_num  = 8'h01;
        bus.sw_in    = 8'h02;
        bus.in_last  = 1'b1;
        step();
        chk("idle in_ready", 32'(bus.in_ready), 32'd0);
        chk("idle res_valid", 32'(bus.res_valid), 32'd0);
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("idle pair_cnt hold", 32'(bus.pair_cnt), 32'd1);
        chk("idle err_cnt hold", 32'(bus.err_cnt), 32'd1);
        chk("idle err hold", 32'(bus.err), 32'd1);

        // asynchronous reset after two accepted pairs
        do_start();
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.seq_num  = vecs[i].seq;
            bus.sw_in    = vecs[i].sw;
            bus.in_last  = 1'b0;
            step();
        end
        bus.in_valid = 1'b0;
        chk("midrun pair_cnt before reset", 32'(bus.pair_cnt), 32'd2);
        #3 rst = 1'b1;
        #1;
        chk("midrun reset busy", 32'(bus.busy), 32'd0);
        chk("midrun reset in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrun reset pair_cnt", 32'(bus.pair_cnt), 32'd0);
        chk("midrun reset res_valid", 32'(bus.res_valid), 32'd0);
        chk("midrun reset err", 32'(bus.err), 32'd0);
        chk("midrun reset first_err_idx", 32'(bus.first_err_idx), 32'hFF);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("no done after reset %0d", k), 32'(bus.done), 32'd0);
        end
        run_chain(0);

        // saturation with the 2-bit counter instance
        do_start();
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.seq_num  = 8'h00;
            bus.sw_in    = 8'h00;
            bus.in_last  = (k == 4);
            step();
            chk($sformatf("sat res_fail %0d", k), 32'(bus2.res_fail), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        step();
        chk("sat done", 32'(bus2.done), 32'd1);
        step();
        chk("sat pair_cnt", 32'(bus2.pair_cnt), 32'd3);
        chk("sat err_cnt", 32'(bus2.err_cnt), 32'd3);
        chk("sat first_err_idx", 32'(bus2.first_err_idx), 32'd0);
        chk("sat err", 32'(bus2.err), 32'd1);
        chk("wide pair_cnt", 32'(bus.pair_cnt), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
